decode: RTL and testbench
=========================

# decode

Instruction decode stage of the odyssey-core pipeline. It sits directly downstream of `fetch`, accepting one 32-bit RV32I instruction and its PC per handshake. It splits the instruction into register indices, a sign-extended immediate and control signals, and holds them in a single pipeline register for the execute stage. It supports backpressure (valid/ready), pipeline flush on redirect, and illegal-instruction flagging.

## Interface
- `DATA_WIDTH`, 32, width of instruction, PC and immediate
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  fetch presents a valid instruction
- `in_ready`  out  1  decode accepts this cycle
- `in_instruction`  in  DATA_WIDTH  raw instruction word
- `in_pc`  in  DATA_WIDTH  address of `in_instruction`
- `flush`  in  1  discard held and incoming instruction (branch or jump redirect)
- `out_valid`  out  1  decoded bundle valid
- `out_ready`  in  1  execute accepts the bundle
- `out_pc`  out  DATA_WIDTH  registered PC
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices
- `out_imm`  out  DATA_WIDTH  sign-extended immediate
- `out_alu_op`  out  5  ALU operation, encoded per `riscv_pkg::alu_op_t`
- `out_alu_src_imm`  out  1  ALU operand B is the immediate
- `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_branch`, `out_jump`  out  1 each  control flags
- `out_illegal`  out  1  opcode, funct3 or funct7 combination is unsupported

## Operation
- **Storage:** a single-entry pipeline register. The `out_*` ports are driven directly from flops.
- **Ready:** `in_ready = !out_valid || out_ready` (combinational).
- **Capture:** when `in_valid && in_ready && !flush`, the decoded bundle is written and `out_valid` is set to 1.
- **Drain:** when `out_valid && out_ready` and there is no capture, `out_valid` is cleared to 0.
- **Flush priority:** `flush` has priority over capture and hold. On the next edge `out_valid` is 0 and the incoming instruction is dropped. Data fields may keep stale values.
- **Hold:** while `out_valid && !out_ready`, every `out_*` output stays stable.
- **Opcodes decoded:**
  - LUI: alu_op `PASSB`.
  - AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - FENCE: decoded as a NOP with reg_write 0.
  - SYSTEM: ECALL and EBREAK raise `out_illegal` (trap path handled downstream).
- **ALU codes:** ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
- **Immediate formats:** I, S, B, U and J. The result is always sign-extended from the instruction MSB, except U-type, which is `{inst[31:12], 12'b0}`.
- **Register write suppression:** `rd == 0` forces `out_reg_write` to 0.
- **Illegal instructions:** set `out_illegal` to 1 and force reg_write, mem_read, mem_write, branch and jump to 0. The bundle is still passed as valid.

## Timing
- Latency is 1 cycle from accepted input to `out_valid`.
- Throughput is 1 instruction per cycle while `out_ready` is 1.
- Reset values: `out_valid` 0, and every other `out_*` output 0. `in_ready` reads 1 during reset.
- If `flush` and `out_ready` are both high in the same cycle, the flush wins and `out_valid` becomes 0.
- Reset asserted mid-stall clears the bundle immediately (asynchronously).

## Configuration
- **`DECODE_RV32M_EN` defined:** OP with funct7 `0000001` decodes to MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23, with reg_write 1.
- **`DECODE_RV32M_EN` undefined:** the same encodings set `out_illegal`.

## Structure
- **`riscv_pkg` package** contains:
  - opcode localparams;
  - `alu_op_t` as a 5-bit enum;
  - `imm_fmt_t` enum (I, S, B, U, J, NONE);
  - a decoded-bundle struct.
- **`imm_gen` sub-module:** purely combinational; inputs are the instruction and `imm_fmt_t`, output is `out_imm`.

## Test plan
- **ADDI:** `0x00500093` (ADDI x1,x0,5) with `out_ready` 1 -> one cycle later `out_valid` 1, rd 1, rs1 0, imm 5, alu ADD, alu_src_imm 1, reg_write 1.
- **Branch immediate:** `0xFE000EE3` (BEQ x0,x0,-4) -> imm `0xFFFFFFFC`, branch 1, alu SUB, reg_write 0.
- **Backpressure:** hold `out_ready` 0 for 3 cycles after a capture -> `in_ready` 0 and outputs unchanged. Raise `out_ready` -> next instruction captured on that edge with no loss and no duplication.
- **Flush:** assert `flush` together with `in_valid` and with `out_valid` 1 -> `out_valid` 0 next cycle, and the flushed instruction never appears at the output.
- **Illegal word:** `0xFFFFFFFF` -> `out_illegal` 1 and all write/memory/branch flags 0.
- **RV32M:** `0x022081B3` (MUL x3,x1,x2) -> with `DECODE_RV32M_EN`, alu_op 16 and reg_write 1; without it, `out_illegal` 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, ALU operation codes, immediate formats
// and the registered control bundle handed from decode to execute.
package riscv_pkg;

    localparam int unsigned INST_W    = 32;
    localparam int unsigned REG_IDX_W = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        alu_op_t              alu_op;
        logic                 alu_src_imm;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic                 branch;
        logic                 jump;
        logic                 illegal;
    } decoded_t;

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: assembles the I/S/B/U/J immediate from the upper
// instruction bits and sign-extends it to DATA_WIDTH.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [INST_W-1:7]     instruction,
    input  imm_fmt_t              fmt,
    output logic [DATA_WIDTH-1:0] out_imm
);

    logic [INST_W-1:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
            IMM_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            IMM_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
            IMM_U: imm32 = {instruction[31:12], 12'b0};
            IMM_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign out_imm = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/decode.sv
// RV32I decode stage: one-entry valid/ready pipeline register with flush and
// illegal-instruction flagging. Define DECODE_RV32M_EN to decode the M extension.
module decode
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_instruction,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [4:0]            out_alu_op,
    output logic                  out_alu_src_imm,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_branch,
    output logic                  out_jump,
    output logic                  out_illegal
);

    logic [INST_W-1:0]     inst;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    decoded_t              dec_c;
    imm_fmt_t              fmt_c;
    logic [DATA_WIDTH-1:0] imm_c;
    decoded_t              bundle_q;
    logic                  capture;

    assign inst   = in_instruction[INST_W-1:0];
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .instruction (inst[INST_W-1:7]),
        .fmt         (fmt_c),
        .out_imm     (imm_c)
    );

    // Opcode/funct decode into the control bundle
    always_comb begin
        dec_c        = '0;
        dec_c.rs1    = inst[19:15];
        dec_c.rs2    = inst[24:20];
        dec_c.rd     = inst[11:7];
        dec_c.alu_op = ALU_ADD;
        fmt_c        = IMM_NONE;
        case (opcode)
            OPC_LUI: begin
                dec_c.alu_op      = ALU_PASSB;
                dec_c.alu_src_imm = 1'b1;
                dec_c.reg_write   = 1'b1;
                fmt_c             = IMM_U;
            end
            OPC_AUIPC: begin
                dec_c.alu_src_imm = 1'b1;
                dec_c.reg_write   = 1'b1;
                fmt_c             = IMM_U;
            end
            OPC_JAL: begin
                dec_c.alu_src_imm = 1'b1;
                dec_c.reg_write   = 1'b1;
                dec_c.jump        = 1'b1;
                fmt_c             = IMM_J;
            end
            OPC_JALR: begin
                dec_c.alu_src_imm = 1'b1;
                dec_c.reg_write   = 1'b1;
                dec_c.jump        = 1'b1;
                dec_c.illegal     = (funct3 != 3'b000);
                fmt_c             = IMM_I;
            end
            OPC_BRANCH: begin
                dec_c.branch = 1'b1;
                fmt_c        = IMM_B;
                case (funct3)
                    3'b000, 3'b001: dec_c.alu_op = ALU_SUB;
                    3'b100, 3'b101: dec_c.alu_op = ALU_SLT;
                    3'b110, 3'b111: dec_c.alu_op = ALU_SLTU;
                    default:        dec_c.illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_c.alu_src_imm = 1'b1;
                dec_c.reg_write   = 1'b1;
                dec_c.mem_read    = 1'b1;
                dec_c.illegal     = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                                    (funct3 == 3'b111);
                fmt_c             = IMM_I;
            end
            OPC_STORE: begin
                dec_c.alu_src_imm = 1'b1;
                dec_c.mem_write   = 1'b1;
                dec_c.illegal     = (funct3 > 3'b010);
                fmt_c             = IMM_S;
            end
            OPC_OP_IMM: begin
                dec_c.alu_src_imm = 1'b1;
                dec_c.reg_write   = 1'b1;
                fmt_c             = IMM_I;
                case (funct3)
                    3'b000: dec_c.alu_op = ALU_ADD;
                    3'b010: dec_c.alu_op = ALU_SLT;
                    3'b011: dec_c.alu_op = ALU_SLTU;
                    3'b100: dec_c.alu_op = ALU_XOR;
                    3'b110: dec_c.alu_op = ALU_OR;
                    3'b111: dec_c.alu_op = ALU_AND;
                    3'b001: begin
                        dec_c.alu_op  = ALU_SLL;
                        dec_c.illegal = (funct7 != 7'b0000000);
                    end
                    default: begin
                        if (funct7 == 7'b0000000) begin
                            dec_c.alu_op = ALU_SRL;
                        end else if (funct7 == 7'b0100000) begin
                            dec_c.alu_op = ALU_SRA;
                        end else begin
                            dec_c.illegal = 1'b1;
                        end
                    end
                endcase
            end
            OPC_OP: begin
                dec_c.reg_write = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  dec_c.alu_op = ALU_ADD;
                            3'b001:  dec_c.alu_op = ALU_SLL;
                            3'b010:  dec_c.alu_op = ALU_SLT;
                            3'b011:  dec_c.alu_op = ALU_SLTU;
                            3'b100:  dec_c.alu_op = ALU_XOR;
                            3'b101:  dec_c.alu_op = ALU_SRL;
                            3'b110:  dec_c.alu_op = ALU_OR;
                            default: dec_c.alu_op = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000) begin
                            dec_c.alu_op = ALU_SUB;
                        end else if (funct3 == 3'b101) begin
                            dec_c.alu_op = ALU_SRA;
                        end else begin
                            dec_c.illegal = 1'b1;
                        end
                    end
`ifdef DECODE_RV32M_EN
                    // M-extension codes are contiguous from MUL, indexed by funct3
                    7'b0000001: dec_c.alu_op = alu_op_t'(5'(ALU_MUL) | 5'(funct3));
`endif
                    default: dec_c.illegal = 1'b1;
                endcase
            end
            OPC_FENCE: begin
                // Behaves as ADDI x0,x0,0
                dec_c.alu_src_imm = 1'b1;
            end
            OPC_SYSTEM: begin
                dec_c.illegal = 1'b1;
            end
            default: begin
                dec_c.illegal = 1'b1;
            end
        endcase

        if (dec_c.rd == 5'd0) begin
            dec_c.reg_write = 1'b0;
        end
        if (dec_c.illegal) begin
            dec_c.reg_write = 1'b0;
            dec_c.mem_read  = 1'b0;
            dec_c.mem_write = 1'b0;
            dec_c.branch    = 1'b0;
            dec_c.jump      = 1'b0;
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Pipeline register; flush beats capture and drain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_imm   <= '0;
            bundle_q  <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (capture) begin
                out_pc   <= in_pc;
                out_imm  <= imm_c;
                bundle_q <= dec_c;
            end
        end
    end

    assign out_rs1         = bundle_q.rs1;
    assign out_rs2         = bundle_q.rs2;
    assign out_rd          = bundle_q.rd;
    assign out_alu_op      = bundle_q.alu_op;
    assign out_alu_src_imm = bundle_q.alu_src_imm;
    assign out_reg_write   = bundle_q.reg_write;
    assign out_mem_read    = bundle_q.mem_read;
    assign out_mem_write   = bundle_q.mem_write;
    assign out_branch      = bundle_q.branch;
    assign out_jump        = bundle_q.jump;
    assign out_illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for the decode stage.
module tb_decode;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [4:0]  out_alu_op;
    logic        out_alu_src_imm;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_branch;
    logic        out_jump;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    decode dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .in_pc           (in_pc),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_rs1         (out_rs1),
        .out_rs2         (out_rs2),
        .out_rd          (out_rd),
        .out_imm         (out_imm),
        .out_alu_op      (out_alu_op),
        .out_alu_src_imm (out_alu_src_imm),
        .out_reg_write   (out_reg_write),
        .out_mem_read    (out_mem_read),
        .out_mem_write   (out_mem_write),
        .out_branch      (out_branch),
        .out_jump        (out_jump),
        .out_illegal     (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        @(negedge clk);
        in_valid       = v;
        in_instruction = instr;
        in_pc          = pc;
    endtask

    // Flags packed as {src_imm, reg_write, mem_read, mem_write, branch, jump, illegal}
    task automatic issue(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [4:0] alu, input logic [6:0] flags);
        logic [6:0] got_flags;
        logic [6:0] mask;
        drive(1'b1, instr, pc);
        @(posedge clk);
        #1;
        got_flags = {out_alu_src_imm, out_reg_write, out_mem_read, out_mem_write,
                     out_branch, out_jump, out_illegal};
        mask      = flags[0] ? 7'h3F : 7'h7F;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".pc"},    out_pc, pc);
        check({tag, ".rs1"},   32'(out_rs1), 32'(rs1));
        check({tag, ".rs2"},   32'(out_rs2), 32'(rs2));
        check({tag, ".rd"},    32'(out_rd), 32'(rd));
        check({tag, ".flags"}, 32'(got_flags & mask), 32'(flags & mask));
        if (!flags[0]) begin
            check({tag, ".imm"}, out_imm, imm);
            check({tag, ".alu"}, 32'(out_alu_op), 32'(alu));
        end
    endtask

    initial begin
        rst            = 1'b0;
        in_valid       = 1'b0;
        in_instruction = '0;
        in_pc          = '0;
        flush          = 1'b0;
        out_ready      = 1'b0;

        #12;
        check("rst.valid",    32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.pc",       out_pc, 32'd0);
        check("rst.imm",      out_imm, 32'd0);
        check("rst.flags",    32'({out_reg_write, out_mem_read, out_mem_write, out_branch,
                                   out_jump, out_illegal, out_alu_src_imm}), 32'd0);

        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;

        // Back-to-back stream at full throughput
        issue("addi",  32'h00500093, 32'h100, 5'd0, 5'd5,  5'd1,  32'd5,        5'd0,  7'b1100000);
        issue("beq",   32'hFE000EE3, 32'h104, 5'd0, 5'd0,  5'd29, 32'hFFFFFFFC, 5'd1,  7'b0000100);
        issue("lui",   32'h123450B7, 32'h108, 5'd8, 5'd3,  5'd1,  32'h12345000, 5'd10, 7'b1100000);
        issue("sw",    32'h0020A423, 32'h10C, 5'd1, 5'd2,  5'd8,  32'd8,        5'd0,  7'b1001000);
        issue("jal",   32'h010000EF, 32'h110, 5'd0, 5'd16, 5'd1,  32'd16,       5'd0,  7'b1100010);
        issue("nop",   32'h00000013, 32'h114, 5'd0, 5'd0,  5'd0,  32'd0,        5'd0,  7'b1000000);
        issue("srai",  32'h40335293, 32'h118, 5'd6, 5'd3,  5'd5,  32'h403,      5'd7,  7'b1100000);
        issue("fence", 32'h0000000F, 32'h11C, 5'd0, 5'd0,  5'd0,  32'd0,        5'd0,  7'b1000000);
        issue("ones",  32'hFFFFFFFF, 32'h120, 5'd31, 5'd31, 5'd31, 32'd0,       5'd0,  7'b0000001);
        issue("ecall", 32'h00000073, 32'h124, 5'd0, 5'd0,  5'd0,  32'd0,        5'd0,  7'b0000001);
`ifdef DECODE_RV32M_EN
        issue("mul",   32'h022081B3, 32'h128, 5'd1, 5'd2,  5'd3,  32'd0,        5'd16, 7'b0100000);
`else
        issue("mul",   32'h022081B3, 32'h128, 5'd1, 5'd2,  5'd3,  32'd0,        5'd0,  7'b0000001);
`endif

        // Backpressure: stall three cycles with a new instruction waiting
        drive(1'b1, 32'h00700113, 32'h12C);
        out_ready = 1'b0;
        #1;
        check("bp.in_ready0", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_pc",    out_pc, 32'h128);
            check("bp.hold_rd",    32'(out_rd), 32'd3);
            check("bp.in_ready",   32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.cap_valid", 32'(out_valid), 32'd1);
        check("bp.cap_pc",    out_pc, 32'h12C);
        check("bp.cap_imm",   out_imm, 32'd7);
        check("bp.cap_rd",    32'(out_rd), 32'd2);
        drive(1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("bp.no_dup", 32'(out_valid), 32'd0);

        // Flush while stalled with a held bundle and a new input
        issue("f1", 32'h00500093, 32'h200, 5'd0, 5'd5, 5'd1, 32'd5, 5'd0, 7'b1100000);
        drive(1'b1, 32'h00700113, 32'h204);
        out_ready = 1'b0;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        check("flush.valid", 32'(out_valid), 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        flush     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("flush.dropped", 32'(out_valid), 32'd0);

        // Flush together with out_ready: flush still wins
        issue("f2", 32'h00500093, 32'h208, 5'd0, 5'd5, 5'd1, 32'd5, 5'd0, 7'b1100000);
        drive(1'b1, 32'h00700113, 32'h20C);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_rdy.valid", 32'(out_valid), 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        flush = 1'b0;

        // Asynchronous reset in the middle of a stall
        issue("r1", 32'h00500093, 32'h300, 5'd0, 5'd5, 5'd1, 32'd5, 5'd0, 7'b1100000);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst.valid",    32'(out_valid), 32'd0);
        check("arst.pc",       out_pc, 32'd0);
        check("arst.imm",      out_imm, 32'd0);
        check("arst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
